// File: rtl/cnn_layer_sequencer.sv
// Steps a shared CNN layer engine through up to LAYER_COUNT passes.
// Each pass uses its own programmed (x, y, z) base. A watchdog and an abort recover from a hung engine.
module cnn_layer_sequencer #(
  parameter int LAYER_COUNT = 4,
  parameter int ADDR_W      = 9,
  parameter int Z_W         = 8,
  parameter int TIMEOUT     = 65535
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_we,
  input  logic [$clog2(LAYER_COUNT)-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0]                  cfg_x,
  input  logic [ADDR_W-1:0]                  cfg_y,
  input  logic [Z_W-1:0]                     cfg_z,
  input  logic [$clog2(LAYER_COUNT+1)-1:0]   num_layers,
  input  logic                               run,
  input  logic                               abort,
  input  logic                               layer_done,
  output logic                               layer_start,
  output logic [ADDR_W-1:0]                  x_inp,
  output logic [ADDR_W-1:0]                  y_inp,
  output logic [Z_W-1:0]                     z_inp,
  output logic                               busy,
  output logic [$clog2(LAYER_COUNT)-1:0]     cur_layer,
  output logic                               all_done,
  output logic                               err,
  output logic [2:0]                         dbg_state
);

  localparam int IDX_W = $clog2(LAYER_COUNT);
  localparam int CNT_W = $clog2(LAYER_COUNT + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(LAYER_COUNT);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] tbl_x [LAYER_COUNT];
  logic [ADDR_W-1:0] tbl_y [LAYER_COUNT];
  logic [Z_W-1:0]    tbl_z [LAYER_COUNT];

  logic [CNT_W-1:0] count;
  logic [WD_W-1:0]  wdog;
  logic             run_go;
  logic             advance;
  logic             timeout_hit;
  logic             last_pass;

  // Handshake: run is a level request and is taken only in IDLE. layer_start is a one-cycle
  // command to the engine. layer_done is honoured only in WAIT, so a held level cannot skip a pass.
  assign last_pass = (CNT_W'(cur_layer) == count - CNT_W'(1));

  always_comb begin
    state_nxt   = state;
    run_go      = 1'b0;
    advance     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (run && !abort) begin
          run_go    = (num_layers != '0);
          state_nxt = (num_layers != '0) ? S_LOAD : S_FINISH;
        end
      end
      S_LOAD:   state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (layer_done) begin
          advance   = !last_pass;
          state_nxt = last_pass ? S_FINISH : S_LOAD;
        end else if (wdog == WD_LIMIT) begin
          timeout_hit = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // Abort outranks layer_done and the watchdog.
    if (abort && state != S_IDLE) begin
      state_nxt   = S_IDLE;
      advance     = 1'b0;
      timeout_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      count     <= '0;
      wdog      <= '0;
      cur_layer <= '0;
      err       <= 1'b0;
      x_inp     <= '0;
      y_inp     <= '0;
      z_inp     <= '0;
      for (int i = 0; i < LAYER_COUNT; i++) begin
        tbl_x[i] <= '0;
        tbl_y[i] <= '0;
        tbl_z[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (cfg_we && state == S_IDLE && CNT_W'(cfg_idx) < MAX_CNT) begin
        tbl_x[cfg_idx] <= cfg_x;
        tbl_y[cfg_idx] <= cfg_y;
        tbl_z[cfg_idx] <= cfg_z;
      end
      if (run_go) begin
        cur_layer <= '0;
        err       <= 1'b0;
        count     <= (num_layers > MAX_CNT) ? MAX_CNT : num_layers;
      end
      // The table is read one cycle after the run is accepted, so a same-cycle write is always seen.
      if (state == S_LOAD && !abort) begin
        x_inp <= tbl_x[cur_layer];
        y_inp <= tbl_y[cur_layer];
        z_inp <= tbl_z[cur_layer];
      end
      if (state == S_START) begin
        wdog <= '0;
      end else if (state == S_WAIT && !layer_done) begin
        wdog <= wdog + WD_W'(1);
      end
      if (advance) begin
        cur_layer <= cur_layer + IDX_W'(1);
      end
      if (timeout_hit) begin
        err <= 1'b1;
      end
    end
  end

  assign layer_start = (state == S_START);
  assign all_done    = (state == S_FINISH);
  assign busy        = (state != S_IDLE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: multi-pass runs, zero-pass run, watchdog, abort,
// ignored writes and stray done pulses, and asynchronous reset.
`timescale 1ns/1ps
module tb_cnn_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [8:0] cfg_x = '0;
  logic [8:0] cfg_y = '0;
  logic [7:0] cfg_z = '0;
  logic [2:0] num_layers = '0;
  logic       run = 1'b0;
  logic       abort = 1'b0;
  logic       layer_done;
  logic       eng_done = 1'b0;
  logic       man_done = 1'b0;
  logic       eng_en = 1'b0;

  logic       layer_start;
  logic [8:0] x_inp;
  logic [8:0] y_inp;
  logic [7:0] z_inp;
  logic       busy;
  logic [1:0] cur_layer;
  logic       all_done;
  logic       err;
  logic [2:0] dbg_state;

  logic [27:0] exp_q[$];
  int n_checks  = 0;
  int n_errors  = 0;
  int n_start   = 0;
  int n_alldone = 0;
  int s0, d0;

  assign layer_done = eng_done | man_done;

  cnn_layer_sequencer #(
    .LAYER_COUNT(4),
    .ADDR_W(9),
    .Z_W(8),
    .TIMEOUT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_x(cfg_x),
    .cfg_y(cfg_y),
    .cfg_z(cfg_z),
    .num_layers(num_layers),
    .run(run),
    .abort(abort),
    .layer_done(layer_done),
    .layer_start(layer_start),
    .x_inp(x_inp),
    .y_inp(y_inp),
    .z_inp(z_inp),
    .busy(busy),
    .cur_layer(cur_layer),
    .all_done(all_done),
    .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d checks exp finish", n_checks);
    $fatal(1, "bench time limit");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] mk(input int idx, input int x, input int y, input int z);
    return {2'(idx), 9'(x), 9'(y), 8'(z)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int z);
    cfg_we  = 1'b1;
    cfg_idx = 2'(idx);
    cfg_x   = 9'(x);
    cfg_y   = 9'(y);
    cfg_z   = 8'(z);
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic start_run(input int n);
    num_layers = 3'(n);
    run        = 1'b1;
    tick();
    run        = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    logic prev;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      prev = layer_done;
      tick();
      if (all_done) begin
        seen = 1'b1;
        check("done_to_alldone", 32'(prev), 32'd1);
      end
    end
    check("all_done_seen", 32'(seen), 32'd1);
  endtask

  // ---------------- engine model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (layer_start && eng_en) begin
        repeat (10) @(posedge clk);
        #1 eng_done = 1'b1;
        @(posedge clk);
        #1 eng_done = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (layer_start) begin
      n_start++;
      if (exp_q.size() == 0) check("unexpected_start", 32'(layer_start), 32'd0);
      else check("start_fields", 32'({cur_layer, x_inp, y_inp, z_inp}), 32'(exp_q.pop_front()));
    end
    if (all_done) n_alldone++;
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(layer_start), 32'd0);
    check("rst_alldone", 32'(all_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'({x_inp, y_inp, z_inp}), 32'd0);
    check("rst_cur", 32'(cur_layer), 32'd0);
    rst = 1'b1;
    tick();

    cfg_write(0, 0, 256, 0);
    cfg_write(1, 16, 272, 8);
    cfg_write(2, 32, 288, 16);

    // three-pass run
    eng_en = 1'b1;
    exp_q.push_back(mk(0, 0, 256, 0));
    exp_q.push_back(mk(1, 16, 272, 8));
    exp_q.push_back(mk(2, 32, 288, 16));
    s0 = n_start; d0 = n_alldone;
    start_run(3);
    check("run_busy", 32'(busy), 32'd1);
    check("run_no_start_yet", 32'(layer_start), 32'd0);
    tick();
    check("run_start_latency", 32'(layer_start), 32'd1);
    run_to_done(200);
    check("t1_cur_last", 32'(cur_layer), 32'd2);
    tick();
    check("t1_busy_after", 32'(busy), 32'd0);
    check("t1_alldone_one_cycle", 32'(all_done), 32'd0);
    check("t1_starts", 32'(n_start - s0), 32'd3);
    check("t1_alldones", 32'(n_alldone - d0), 32'd1);
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

    // zero-pass run
    s0 = n_start; d0 = n_alldone;
    start_run(0);
    check("z_alldone", 32'(all_done), 32'd1);
    check("z_busy", 32'(busy), 32'd1);
    tick();
    check("z_alldone_off", 32'(all_done), 32'd0);
    check("z_busy_off", 32'(busy), 32'd0);
    check("z_no_start", 32'(n_start - s0), 32'd0);
    check("z_one_alldone", 32'(n_alldone - d0), 32'd1);

    // watchdog: engine silent
    eng_en = 1'b0;
    exp_q.push_back(mk(0, 0, 256, 0));
    d0 = n_alldone;
    start_run(3);
    tick();
    check("to_start", 32'(layer_start), 32'd1);
    repeat (20) tick();
    check("to_err_before", 32'(err), 32'd0);
    check("to_busy_before", 32'(busy), 32'd1);
    tick();
    check("to_err", 32'(err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    check("to_no_alldone", 32'(n_alldone - d0), 32'd0);
    eng_en = 1'b1;
    exp_q.push_back(mk(0, 0, 256, 0));
    exp_q.push_back(mk(1, 16, 272, 8));
    exp_q.push_back(mk(2, 32, 288, 16));
    start_run(3);
    check("to_err_cleared", 32'(err), 32'd0);
    run_to_done(200);
    tick();
    check("to_recover_alldone", 32'(n_alldone - d0), 32'd1);
    check("to_recover_queue", 32'(exp_q.size()), 32'd0);

    // abort together with layer_done on pass 1
    eng_en = 1'b0;
    exp_q.push_back(mk(0, 0, 256, 0));
    exp_q.push_back(mk(1, 16, 272, 8));
    s0 = n_start; d0 = n_alldone;
    start_run(3);
    tick();
    repeat (3) tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("ab_cur_advanced", 32'(cur_layer), 32'd1);
    check("ab_load_no_start", 32'(layer_start), 32'd0);
    tick();
    check("ab_done_to_start", 32'(layer_start), 32'd1);
    tick();
    repeat (2) tick();
    man_done = 1'b1;
    abort    = 1'b1;
    tick();
    man_done = 1'b0;
    abort    = 1'b0;
    check("ab_idle", 32'(busy), 32'd0);
    check("ab_err", 32'(err), 32'd0);
    check("ab_addr_hold", 32'({x_inp, y_inp, z_inp}), 32'({9'd16, 9'd272, 8'd8}));
    repeat (15) tick();
    check("ab_starts", 32'(n_start - s0), 32'd2);
    check("ab_no_alldone", 32'(n_alldone - d0), 32'd0);
    check("ab_queue", 32'(exp_q.size()), 32'd0);

    // abort in IDLE suppresses run
    num_layers = 3'd2;
    run   = 1'b1;
    abort = 1'b1;
    tick();
    run   = 1'b0;
    abort = 1'b0;
    check("ab_idle_run_blocked", 32'(busy), 32'd0);

    // stray done in IDLE, write while busy, stray done in START
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("stray_idle", 32'(busy), 32'd0);
    eng_en = 1'b1;
    exp_q.push_back(mk(0, 0, 256, 0));
    exp_q.push_back(mk(1, 16, 272, 8));
    exp_q.push_back(mk(2, 32, 288, 16));
    d0 = n_alldone;
    start_run(3);
    cfg_write(1, 100, 101, 102);
    check("busy_wr_start", 32'(layer_start), 32'd1);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("stray_start_cur", 32'(cur_layer), 32'd0);
    check("stray_start_state", 32'(dbg_state), 32'd3);
    run_to_done(200);
    tick();
    check("busy_wr_alldone", 32'(n_alldone - d0), 32'd1);
    check("busy_wr_queue", 32'(exp_q.size()), 32'd0);

    // write to entry 0 in the same cycle the run is accepted
    exp_q.push_back(mk(0, 50, 60, 70));
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_x = 9'd50; cfg_y = 9'd60; cfg_z = 8'd70;
    num_layers = 3'd1;
    run = 1'b1;
    tick();
    cfg_we = 1'b0;
    run    = 1'b0;
    run_to_done(200);
    tick();
    check("same_cycle_wr_queue", 32'(exp_q.size()), 32'd0);

    // asynchronous reset in WAIT
    eng_en = 1'b0;
    exp_q.push_back(mk(0, 50, 60, 70));
    start_run(2);
    tick();
    repeat (3) tick();
    #1 rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_start", 32'(layer_start), 32'd0);
    check("arst_addr", 32'({x_inp, y_inp, z_inp}), 32'd0);
    check("arst_cur", 32'(cur_layer), 32'd0);
    @(negedge clk);
    check("arst_start_negedge", 32'(layer_start), 32'd0);
    tick();
    check("arst_start_held", 32'(layer_start), 32'd0);
    rst = 1'b1;
    tick();
    eng_en = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0));
    start_run(2);
    run_to_done(200);
    tick();
    check("arst_table_zero_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
